ahb_mtx_input_hold: RTL and testbench

// - Requester-side input stage of the AHB bus matrix: one per master port, facing a target arbiter.
// - Accepts master address phases and raises a request to the target arbiter.
// - When a transfer is not granted, it is captured in a holding register and the master is stalled.
// - Forwards the target's HREADY/HRESP back to the master during the data phase.

---
 rtl/ahb_mtx_pkg.sv | 54 +++++
 rtl/ahb_mtx_hold_reg.sv | 91 +++++++++
 rtl/ahb_mtx_input_hold.sv | 160 ++++++++++++++++
 tb/tb_ahb_mtx_input_hold.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_pkg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_pkg
// Shared encodings for the AHB bus matrix input stage.
//   - AHB transfer, burst and response encodings.
//   - Input-stage FSM state encoding.
//   - Packed address-phase control bundle passed between the input stage
//     and its holding register.
// ---------------------------------------------------------------------------
package ahb_mtx_pkg;

  // HTRANS encodings
  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  // HBURST encodings
  localparam logic [2:0] BUR_SINGLE = 3'b000;
  localparam logic [2:0] BUR_INCR   = 3'b001;
  localparam logic [2:0] BUR_WRAP4  = 3'b010;
  localparam logic [2:0] BUR_INCR4  = 3'b011;
  localparam logic [2:0] BUR_WRAP8  = 3'b100;
  localparam logic [2:0] BUR_INCR8  = 3'b101;
  localparam logic [2:0] BUR_WRAP16 = 3'b110;
  localparam logic [2:0] BUR_INCR16 = 3'b111;

  // HRESP encodings
  localparam logic RSP_OKAY  = 1'b0;
  localparam logic RSP_ERROR = 1'b1;

  // Input-stage FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  // Address-phase control fields (address travels separately, width is a parameter)
  typedef struct packed {
    logic       sel;
    logic [1:0] trans;
    logic       write;
    logic [2:0] size;
    logic [2:0] burst;
    logic [3:0] prot;
    logic       lock;
  } addr_ctl_t;

  // NONSEQ and SEQ are the only transfer types that carry data
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_mtx_hold_reg.sv
// ---------------------------------------------------------------------------
// ahb_mtx_hold_reg
// Capture register for an address phase that could not be issued, plus the
// mux that chooses between the held phase and the live master phase.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   load            capture live_ctl/live_addr, mark held
//   clear           held phase has been issued, release it
//   sel_ok          HSELS & HREADYS from the master side
//   live_ctl/addr   current master address phase
//   held_valid      a phase is sitting in the register
//   out_ctl/addr    address phase presented towards the arbiter
// Build option: AHB_MTX_HOLD_SEQ_TO_NONSEQ_EN presents a held SEQ as a
// NONSEQ INCR, because arbitration has broken the original burst.
// ---------------------------------------------------------------------------
module ahb_mtx_hold_reg
  import ahb_mtx_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          load,
  input  logic          clear,
  input  logic          sel_ok,
  input  addr_ctl_t     live_ctl,
  input  logic [AW-1:0] live_addr,
  output logic          held_valid,
  output addr_ctl_t     out_ctl,
  output logic [AW-1:0] out_addr
);

  logic          held_valid_q, held_valid_d;
  addr_ctl_t     held_ctl_q, held_ctl_d;
  logic [AW-1:0] held_addr_q, held_addr_d;

  // Next-state of the holding register: load takes the live phase, clear releases it
  always_comb begin
    held_valid_d = held_valid_q;
    held_ctl_d   = held_ctl_q;
    held_addr_d  = held_addr_q;
    if (load) begin
      held_valid_d = 1'b1;
      held_ctl_d   = live_ctl;
      held_addr_d  = live_addr;
    end else if (clear) begin
      held_valid_d = 1'b0;
    end else begin
      held_valid_d = held_valid_q;
    end
  end

  // Holding register flops
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      held_valid_q <= 1'b0;
      held_ctl_q   <= '0;
      held_addr_q  <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      held_ctl_q   <= held_ctl_d;
      held_addr_q  <= held_addr_d;
    end
  end

  // Presented phase: held phase has priority; with nothing held and no
  // valid master select the transfer type is forced to IDLE
  always_comb begin
    out_ctl  = live_ctl;
    out_addr = live_addr;
    if (held_valid_q) begin
      out_ctl  = held_ctl_q;
      out_addr = held_addr_q;
`ifdef AHB_MTX_HOLD_SEQ_TO_NONSEQ_EN
      if (held_ctl_q.trans == TRN_SEQ) begin
        out_ctl.trans = TRN_NONSEQ;
        out_ctl.burst = BUR_INCR;
      end else begin
        out_ctl.trans = held_ctl_q.trans;
      end
`endif
    end else if (!sel_ok) begin
      out_ctl.trans = TRN_IDLE;
    end else begin
      out_ctl = live_ctl;
    end
  end

  assign held_valid = held_valid_q;

endmodule

// File: rtl/ahb_mtx_input_hold.sv
// ---------------------------------------------------------------------------
// ahb_mtx_input_hold
// Master-side input stage of the AHB bus matrix. Raises a request to the
// target arbiter for every live NONSEQ/SEQ, passes granted transfers straight
// through, holds and stalls ungranted ones, and forwards the target's
// HREADY/HRESP to the master during the data phase.
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSELS..HMASTLOCKS        master address phase, HREADYS bus-level ready
//   HREADYOUTS, HRESPS       ready/response back to the master
//   req, grant               arbiter handshake
//   HREADYM, HRESPM          target-side ready/response
//   HSELM..HMASTLOCKM        address phase presented to the arbiter/target mux
// Build option: AHB_MTX_HOLD_SEQ_TO_NONSEQ_EN (see ahb_mtx_hold_reg).
// ---------------------------------------------------------------------------
module ahb_mtx_input_hold
  import ahb_mtx_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSELS,
  input  logic [AW-1:0] HADDRS,
  input  logic [1:0]    HTRANSS,
  input  logic          HWRITES,
  input  logic [2:0]    HSIZES,
  input  logic [2:0]    HBURSTS,
  input  logic [3:0]    HPROTS,
  input  logic          HMASTLOCKS,
  input  logic          HREADYS,
  output logic          HREADYOUTS,
  output logic          HRESPS,
  output logic          req,
  input  logic          grant,
  input  logic          HREADYM,
  input  logic          HRESPM,
  output logic          HSELM,
  output logic [AW-1:0] HADDRM,
  output logic [1:0]    HTRANSM,
  output logic          HWRITEM,
  output logic [2:0]    HSIZEM,
  output logic [2:0]    HBURSTM,
  output logic [3:0]    HPROTM,
  output logic          HMASTLOCKM
);

  state_t    state_q, state_d;
  logic      sel_ok;
  logic      live;
  logic      load;
  logic      clear;
  logic      held_valid;
  addr_ctl_t live_ctl;
  addr_ctl_t out_ctl;

  assign sel_ok = HSELS & HREADYS;
  assign live   = sel_ok & trans_active(HTRANSS);

  assign live_ctl = '{sel:   HSELS,
                      trans: HTRANSS,
                      write: HWRITES,
                      size:  HSIZES,
                      burst: HBURSTS,
                      prot:  HPROTS,
                      lock:  HMASTLOCKS};

  // Next state plus load/clear strobes for the holding register
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if ((state_q == ST_DATA) && !HREADYM) begin
          // Data phase still waited: master is stalled, address is stable
          state_d = ST_DATA;
        end else if (live) begin
          if (grant && HREADYM) begin
            state_d = ST_DATA;
          end else begin
            load    = 1'b1;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (grant && HREADYM) begin
          clear   = 1'b1;
          state_d = ST_DATA;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Master-facing ready/response; the issue cycle out of ST_HOLD still reads 0
  always_comb begin
    HREADYOUTS = 1'b1;
    HRESPS     = RSP_OKAY;
    case (state_q)
      ST_IDLE: begin
        HREADYOUTS = 1'b1;
        HRESPS     = RSP_OKAY;
      end
      ST_HOLD: begin
        HREADYOUTS = 1'b0;
        HRESPS     = RSP_OKAY;
      end
      ST_DATA: begin
        HREADYOUTS = HREADYM;
        HRESPS     = HRESPM;
      end
      default: begin
        HREADYOUTS = 1'b1;
        HRESPS     = RSP_OKAY;
      end
    endcase
  end

  ahb_mtx_hold_reg #(
    .AW (AW)
  ) u_hold_reg (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .load       (load),
    .clear      (clear),
    .sel_ok     (sel_ok),
    .live_ctl   (live_ctl),
    .live_addr  (HADDRS),
    .held_valid (held_valid),
    .out_ctl    (out_ctl),
    .out_addr   (HADDRM)
  );

  assign req        = held_valid | live;
  assign HSELM      = out_ctl.sel;
  assign HTRANSM    = out_ctl.trans;
  assign HWRITEM    = out_ctl.write;
  assign HSIZEM     = out_ctl.size;
  assign HBURSTM    = out_ctl.burst;
  assign HPROTM     = out_ctl.prot;
  assign HMASTLOCKM = out_ctl.lock;

endmodule

// File: tb/tb_ahb_mtx_input_hold.sv
// ---------------------------------------------------------------------------
// tb_ahb_mtx_input_hold
// Self-checking bench for ahb_mtx_input_hold: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ahb_mtx_input_hold;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HMASTLOCKS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic        HRESPS;
  logic        req;
  logic        grant;
  logic        HREADYM;
  logic        HRESPM;
  logic        HSELM;
  logic [31:0] HADDRM;
  logic [1:0]  HTRANSM;
  logic        HWRITEM;
  logic [2:0]  HSIZEM;
  logic [2:0]  HBURSTM;
  logic [3:0]  HPROTM;
  logic        HMASTLOCKM;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  ahb_mtx_input_hold #(.AW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS), .HWRITES(HWRITES),
    .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS), .HMASTLOCKS(HMASTLOCKS),
    .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .req(req), .grant(grant), .HREADYM(HREADYM), .HRESPM(HRESPM),
    .HSELM(HSELM), .HADDRM(HADDRM), .HTRANSM(HTRANSM), .HWRITEM(HWRITEM),
    .HSIZEM(HSIZEM), .HBURSTM(HBURSTM), .HPROTM(HPROTM), .HMASTLOCKM(HMASTLOCKM)
  );

  // Reference model: one address phase may be waiting for the arbiter, and
  // at most one data phase may be outstanding at the target.
  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } phase_t;

  bit     m_waiting;
  bit     m_data_out;
  phase_t m_phase;

  function automatic phase_t live_phase();
    phase_t p;
    p = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES,
          size: HSIZES, burst: HBURSTS, prot: HPROTS, lock: HMASTLOCKS};
    return p;
  endfunction

  function automatic bit live_xfer();
    return HSELS && HREADYS && (HTRANSS == 2'b10 || HTRANSS == 2'b11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_waiting  = 1'b0;
    m_data_out = 1'b0;
    m_phase    = '0;
  endtask

  // Compare every output against what the model predicts for current inputs
  task automatic check_outputs(input string tag);
    phase_t e;
    logic   e_rdy, e_rsp, e_req;
    e_req = m_waiting || live_xfer();
    if (m_waiting) begin
      e_rdy = 1'b0;
      e_rsp = 1'b0;
    end else if (m_data_out) begin
      e_rdy = HREADYM;
      e_rsp = HRESPM;
    end else begin
      e_rdy = 1'b1;
      e_rsp = 1'b0;
    end
    if (m_waiting) begin
      e = m_phase;
`ifdef AHB_MTX_HOLD_SEQ_TO_NONSEQ_EN
      if (e.trans == 2'b11) begin
        e.trans = 2'b10;
        e.burst = 3'b001;
      end
`endif
    end else begin
      e = live_phase();
      if (!(HSELS && HREADYS)) e.trans = 2'b00;
    end
    chk({tag, ".hreadyout"}, 32'(HREADYOUTS), 32'(e_rdy));
    chk({tag, ".hresp"},     32'(HRESPS),     32'(e_rsp));
    chk({tag, ".req"},       32'(req),        32'(e_req));
    chk({tag, ".hsel"},      32'(HSELM),      32'(e.sel));
    chk({tag, ".haddr"},     HADDRM,          e.addr);
    chk({tag, ".htrans"},    32'(HTRANSM),    32'(e.trans));
    chk({tag, ".hwrite"},    32'(HWRITEM),    32'(e.write));
    chk({tag, ".hsize"},     32'(HSIZEM),     32'(e.size));
    chk({tag, ".hburst"},    32'(HBURSTM),    32'(e.burst));
    chk({tag, ".hprot"},     32'(HPROTM),     32'(e.prot));
    chk({tag, ".hlock"},     32'(HMASTLOCKM), 32'(e.lock));
  endtask

  // Advance the model across one rising edge using the inputs sampled there
  task automatic model_clock();
    if (m_waiting) begin
      if (grant && HREADYM) begin
        m_waiting  = 1'b0;
        m_data_out = 1'b1;
      end
    end else if (m_data_out && !HREADYM) begin
      m_data_out = 1'b1;
    end else if (live_xfer()) begin
      if (grant && HREADYM) begin
        m_data_out = 1'b1;
      end else begin
        m_waiting  = 1'b1;
        m_data_out = 1'b0;
        m_phase    = live_phase();
      end
    end else begin
      m_data_out = 1'b0;
    end
  endtask

  // One bus cycle: check mid-cycle, clock, then let inputs change after the edge
  task automatic step(input string tag);
    @(negedge HCLK);
    check_outputs(tag);
    @(posedge HCLK);
    model_clock();
    #1;
  endtask

  task automatic drive(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic write, input logic [2:0] burst);
    HSELS      = sel;
    HTRANSS    = trans;
    HADDRS     = addr;
    HWRITES    = write;
    HBURSTS    = burst;
    HSIZES     = 3'b010;
    HPROTS     = 4'b0011;
    HMASTLOCKS = 1'b0;
    HREADYS    = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'b000);
    grant   = 1'b0;
    HREADYM = 1'b1;
    HRESPM  = 1'b0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst.hreadyout", 32'(HREADYOUTS), 32'd1);
    chk("rst.hresp",     32'(HRESPS),     32'd0);
    chk("rst.req",       32'(req),        32'd0);
    chk("rst.htrans",    32'(HTRANSM),    32'd0);
    HRESETn = 1'b1;

    // Granted pass-through, zero latency
    grant = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_1000, 1'b0, 3'b000);
    #1;
    chk("pt.haddr_same_cycle", HADDRM, 32'h0000_1000);
    step("pt.addr");
    drive(1'b1, 2'b00, 32'h0, 1'b0, 3'b000);
    HREADYM = 1'b0;
    #1;
    chk("pt.ready_follows", 32'(HREADYOUTS), 32'd0);
    step("pt.wait");
    HREADYM = 1'b1;
    step("pt.done");

    // Ungranted write is held, presented stably, then issued
    grant = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_2000, 1'b1, 3'b000);
    step("hold.capture");
    drive(1'b1, 2'b10, 32'h0000_2ABC, 1'b0, 3'b000);
    HREADYS = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.hreadyout", 32'(HREADYOUTS), 32'd0);
      chk("hold.req",       32'(req),        32'd1);
      chk("hold.haddr",     HADDRM,          32'h0000_2000);
      chk("hold.hwrite",    32'(HWRITEM),    32'd1);
      step("hold.wait");
    end
    grant = 1'b1;
    #1;
    chk("hold.issue_ready", 32'(HREADYOUTS), 32'd0);
    step("hold.issue");
    drive(1'b1, 2'b00, 32'h0, 1'b0, 3'b000);
    HREADYM = 1'b0;
    step("hold.data_wait");
    HREADYM = 1'b1;
    #1;
    chk("hold.data_ready", 32'(HREADYOUTS), 32'd1);
    step("hold.data_done");

    // INCR4 burst broken by arbitration at beat 3
    drive(1'b1, 2'b10, 32'h0000_3000, 1'b0, 3'b011);
    step("burst.b1");
    drive(1'b1, 2'b11, 32'h0000_3004, 1'b0, 3'b011);
    step("burst.b2");
    grant = 1'b0;
    drive(1'b1, 2'b11, 32'h0000_3008, 1'b0, 3'b011);
    step("burst.b3");
    HREADYS = 1'b0;
    #1;
    chk("burst.haddr", HADDRM, 32'h0000_3008);
`ifdef AHB_MTX_HOLD_SEQ_TO_NONSEQ_EN
    chk("burst.htrans", 32'(HTRANSM), 32'd2);
    chk("burst.hburst", 32'(HBURSTM), 32'd1);
`else
    chk("burst.htrans", 32'(HTRANSM), 32'd3);
    chk("burst.hburst", 32'(HBURSTM), 32'd3);
`endif
    step("burst.held");
    grant = 1'b1;
    step("burst.issue");

    // Two-cycle ERROR response, master goes IDLE in the second cycle
    drive(1'b1, 2'b00, 32'h0, 1'b0, 3'b000);
    HREADYS = 1'b0;
    HREADYM = 1'b0;
    HRESPM  = 1'b1;
    #1;
    chk("err.c1_resp",  32'(HRESPS),     32'd1);
    chk("err.c1_ready", 32'(HREADYOUTS), 32'd0);
    step("err.c1");
    HREADYS = 1'b1;
    HREADYM = 1'b1;
    #1;
    chk("err.c2_resp",  32'(HRESPS),     32'd1);
    chk("err.c2_ready", 32'(HREADYOUTS), 32'd1);
    step("err.c2");
    #1;
    chk("err.idle_resp",  32'(HRESPS),     32'd0);
    chk("err.idle_ready", 32'(HREADYOUTS), 32'd1);
    chk("err.idle_req",   32'(req),        32'd0);
    HRESPM = 1'b0;
    step("err.after");

    // Reset asserted while a transfer is held
    grant = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_4000, 1'b1, 3'b000);
    step("rsthold.capture");
    drive(1'b0, 2'b00, 32'h0, 1'b0, 3'b000);
    #1;
    chk("rsthold.pre_req", 32'(req), 32'd1);
    HRESETn = 1'b0;
    #1;
    model_reset();
    chk("rsthold.req",       32'(req),        32'd0);
    chk("rsthold.hreadyout", 32'(HREADYOUTS), 32'd1);
    chk("rsthold.htrans",    32'(HTRANSM),    32'd0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    step("rsthold.after");

    // BUSY and IDLE are never captured
    grant = 1'b0;
    drive(1'b1, 2'b01, 32'h0000_5000, 1'b0, 3'b001);
    #1;
    chk("busy.req", 32'(req), 32'd0);
    step("busy");
    drive(1'b1, 2'b00, 32'h0000_5004, 1'b0, 3'b001);
    #1;
    chk("idle.req",       32'(req),        32'd0);
    chk("idle.hreadyout", 32'(HREADYOUTS), 32'd1);
    step("idle");
    #1;
    chk("idle.no_capture", 32'(HREADYOUTS), 32'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      HSELS      = ($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0;
      HTRANSS    = 2'($urandom_range(3, 0));
      HADDRS     = $urandom;
      HWRITES    = 1'($urandom_range(1, 0));
      HSIZES     = 3'($urandom_range(2, 0));
      HBURSTS    = 3'($urandom_range(7, 0));
      HPROTS     = 4'($urandom_range(15, 0));
      HMASTLOCKS = 1'($urandom_range(1, 0));
      HREADYS    = ($urandom_range(9, 0) < 8) ? 1'b1 : 1'b0;
      grant      = ($urandom_range(9, 0) < 6) ? 1'b1 : 1'b0;
      HREADYM    = ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0;
      HRESPM     = ($urandom_range(9, 0) < 1) ? 1'b1 : 1'b0;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
